uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter; sits directly upstream of the UART receiver on the same serial line.
- Accepts one byte per valid/ready handshake and serialises it as 8N1: start bit (0), 8 data bits LSB first, stop bit (1).
- Line idles high; bit timing is counted in tx_clk cycles, identical to the receiver's CLKS_PER_BIT convention.

Parameters:
- CLKS_PER_BIT, 521, tx_clk cycles per bit = f_clk / baud (10 MHz / 19200).

Ports:
- tx_clk  input  1  system clock; all state updates on rising edge.
- tx_rst_n  input  1  asynchronous active-low reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte (high only in IDLE).
- tx_out  output  1  serial line output, idle high.
- tx_busy  output  1  frame in progress (not IDLE).
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts immediately: tx_out returns to 1 with no partial stop bit.
- States:
  - IDLE: tx_out=1, tx_ready=1. On tx_valid&&tx_ready, latch tx_data into shift register; go to START next cycle.
  - START: tx_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with index=0.
  - DATA: tx_out=shift[index] for CLKS_PER_BIT cycles per bit. Index 0..7, LSB first. After index 7 completes, go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. tx_done=1 on the final cycle. Go to IDLE next cycle.
- Latency: tx_out falls on the cycle after the handshake edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back: tx_ready rises the cycle after tx_done. The next handshake's start bit follows one IDLE cycle, so minimum inter-frame gap is 1 cycle of idle-high.
- tx_data/tx_valid are ignored while busy. tx_valid held high through a frame does not re-trigger until IDLE.
- tx_out is driven directly from a register (glitch-free).
- Bit counter width: $clog2(CLKS_PER_BIT), minimum 1. It counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary.
- Index counter is 3 bits (4 with parity).
- CLKS_PER_BIT must be >= 2; elaboration error otherwise.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx_out = even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no parity state; 8N1, 10*CLKS_PER_BIT cycles.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4; 3-bit encoding used under all builds);
  - default CLKS_PER_BIT=521;
  - line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One natural sub-module, uart_baud_tick:
  - parameterised bit-period counter with clear input and end-of-bit tick output;
  - reusable by the receiver.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then idle 50 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- Send 0xA5 -> tx_out sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_done high exactly at cycle 40 after the fall. tx_ready=1 on cycle 41.
- tx_valid held high with 0x00 then 0xFF queued -> two frames, 1 idle-high cycle between them; second frame data bits all 1; tx_busy drops only in the gap cycle.
- Assert tx_rst_n low at DATA bit 3 of 0x3C -> tx_out=1 asynchronously, all outputs at reset values. A new send of 0x81 after release transmits correctly.
- Loopback, CLKS_PER_BIT=521: tx_out feeds the receiver; send 0x00, 0x55, 0xFF, 0x81 -> receiver byte output matches each within one frame time.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1 between bit7 and stop. Frame = 44 cycles. With 0x03, parity = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and line levels.
// The state encoding stays 3 bits wide whether or not UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } tx_state_t;

   // 10 MHz clock / 19200 baud
   localparam int CLKS_PER_BIT_DEF = 521;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps to 0.
// 'tick' is high on the last cycle of each bit. 'clr' holds the count at 0.
// The receiver can reuse this block.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 521
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Free-running bit-period counter; it wraps at each bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt_q <= '0;
      else if (clr)    cnt_q <= '0;
      else if (tick)   cnt_q <= '0;
      else             cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. The default frame is 8N1: a start bit, 8 data bits sent LSB
// first, then a stop bit.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
// tx_out is a register. Its next value is decoded from the next state, so the
// start bit appears on the cycle after the handshake edge.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       tx_clk,
   input  logic       tx_rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
   localparam int IDX_W = 4;
`else
   localparam int IDX_W = 3;
`endif

   tx_state_t        state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             out_d;
   logic             bit_clr;
   logic             tick;

   // The bit counter is held at 0 while idle, so every frame starts on a fresh period.
   assign bit_clr = (state_q == IDLE);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (tx_clk),
      .rst_n (tx_rst_n),
      .clr   (bit_clr),
      .tick  (tick)
   );

   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = (state_q == STOP) && tick;

   // State, index, shift register and line register.
   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         tx_out  <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_out  <= out_d;
      end
   end

   // Next-state logic, plus the line level for the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         IDLE:   if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = START;
                 end
         START:  if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                 end
         DATA:   if (tick) begin
                    if (idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
                       state_d = PARITY;
`else
                       state_d = STOP;
`endif
                    end else begin
                       idx_d = idx_q + 1'b1;
                    end
                 end
         PARITY: if (tick) state_d = STOP;
         STOP:   if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   out_d = START_BIT;
         DATA:    out_d = shift_d[idx_d[2:0]];
         PARITY:  out_d = ^shift_d;
         STOP:    out_d = STOP_BIT;
         default: out_d = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Each expected line level comes from the frame
// layout: start bit 0, the data bits LSB first, optional even parity, then stop bit 1.
// A second instance with the full 521-cycle bit period drives a behavioural receiver.
module tb_uart_tx;

   localparam int CPB    = 4;
   localparam int LB_CPB = 521;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       tx_clk = 1'b0;
   logic       tx_rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_out, tx_busy, tx_done;

   logic [7:0] lb_data = 8'h00;
   logic       lb_valid = 1'b0;
   logic       lb_ready, lb_out, lb_busy, lb_done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 tx_clk = ~tx_clk;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .tx_clk   (tx_clk),
      .tx_rst_n (tx_rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_out   (tx_out),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   uart_tx #(.CLKS_PER_BIT(LB_CPB)) dut_lb (
      .tx_clk   (tx_clk),
      .tx_rst_n (tx_rst_n),
      .tx_data  (lb_data),
      .tx_valid (lb_valid),
      .tx_ready (lb_ready),
      .tx_out   (lb_out),
      .tx_busy  (lb_busy),
      .tx_done  (lb_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line level of bit slot i in the frame for byte b.
   function automatic logic line_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_out"},   tx_out,   1);
      chk({tag, "_ready"}, tx_ready, 1);
      chk({tag, "_busy"},  tx_busy,  0);
      chk({tag, "_done"},  tx_done,  0);
   endtask

   // Call at a negedge. The handshake occurs at the following posedge.
   task automatic drive(input logic [7:0] b);
      chk("ready_pre", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
   endtask

   // Checks one whole frame cycle by cycle, then the idle gap cycle after it.
   // After the handshake, tx_data is replaced by nxt.
   task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] nxt);
      @(posedge tx_clk); #1;
      if (!hold) tx_valid = 1'b0;
      tx_data = nxt;
      for (int k = 0; k < NBITS*CPB; k++) begin
         @(negedge tx_clk);
         chk("frame_out",   tx_out,   line_bit(b, k / CPB));
         chk("frame_done",  tx_done,  (k == NBITS*CPB-1));
         chk("frame_busy",  tx_busy,  1);
         chk("frame_ready", tx_ready, 0);
      end
      @(negedge tx_clk);
      check_idle("gap");
   endtask

   // Sends b on the 521-cycle instance and decodes it by mid-bit sampling.
   task automatic lb_send(input logic [7:0] b);
      logic [7:0] got;
      int t;
      got = 8'h00;
      @(negedge tx_clk);
      lb_data  = b;
      lb_valid = 1'b1;
      @(negedge tx_clk);
      lb_valid = 1'b0;
      t = 0;
      while (lb_out !== 1'b0 && t < 2*LB_CPB) begin
         @(negedge tx_clk);
         t++;
      end
      chk("lb_start_seen", lb_out, 0);
      repeat (LB_CPB/2) @(negedge tx_clk);
      chk("lb_start_mid", lb_out, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (LB_CPB) @(negedge tx_clk);
         got[i] = lb_out;
      end
`ifdef UART_TX_PARITY_EN
      repeat (LB_CPB) @(negedge tx_clk);
      chk("lb_parity", lb_out, ^b);
`endif
      repeat (LB_CPB) @(negedge tx_clk);
      chk("lb_stop", lb_out, 1);
      chk("lb_byte", got, b);
      t = 0;
      while (lb_ready !== 1'b1 && t < 2*LB_CPB) begin
         @(negedge tx_clk);
         t++;
      end
      chk("lb_ready", lb_ready, 1);
      chk("lb_busy",  lb_busy,  0);
      chk("lb_done",  lb_done,  0);
   endtask

   initial begin
      logic [7:0] rb;

      // Reset, then 50 idle cycles.
      repeat (3) @(negedge tx_clk);
      check_idle("in_reset");
      tx_rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge tx_clk);
         check_idle("idle50");
      end

      // Single frame: 0xA5.
      drive(8'hA5);
      run_frame(8'hA5, 1'b0, 8'($urandom));

      // tx_valid held high: 0x00, then 0xFF. Each byte gets its own frame,
      // with one idle cycle between them.
      drive(8'h00);
      run_frame(8'h00, 1'b1, 8'hFF);
      run_frame(8'hFF, 1'b0, 8'($urandom));

      // Parity corner bytes: 0x07 (odd count of ones) and 0x03 (even count).
      drive(8'h07);
      run_frame(8'h07, 1'b0, 8'h00);
      drive(8'h03);
      run_frame(8'h03, 1'b0, 8'h00);

      // Random bytes with random idle gaps between frames.
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge tx_clk);
         rb = 8'($urandom);
         drive(rb);
         run_frame(rb, 1'b0, 8'($urandom));
      end

      // Reset asserted during data bit 3 of 0x3C.
      drive(8'h3C);
      @(posedge tx_clk); #1;
      tx_valid = 1'b0;
      repeat (CPB + 3*CPB + 2) @(negedge tx_clk);
      chk("pre_rst_bit3", tx_out, line_bit(8'h3C, 4));
      chk("pre_rst_busy", tx_busy, 1);
      tx_rst_n = 1'b0;
      #1;
      check_idle("rst_async");
      repeat (3) begin
         @(negedge tx_clk);
         check_idle("rst_hold");
      end
      tx_rst_n = 1'b1;
      @(negedge tx_clk);
      check_idle("rst_release");
      drive(8'h81);
      run_frame(8'h81, 1'b0, 8'h00);

      // Loopback at the full bit period.
      lb_send(8'h00);
      lb_send(8'h55);
      lb_send(8'hFF);
      lb_send(8'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
